// File: rtl/dsm_pkg.sv
// Shared delta-sigma stage definitions: default widths, midscale, decimator word layout.
package dsm_pkg;

    localparam int unsigned DSM_DATA_W   = 12;
    localparam int unsigned DSM_SCALE_W  = 8;
    localparam int unsigned DSM_LOG2_DEC = 4;
    localparam int unsigned DSM_FIFO_AW  = 3;
    localparam int unsigned DSM_OUT_W    = DSM_DATA_W + DSM_LOG2_DEC;
    localparam int unsigned DSM_WORD_W   = DSM_OUT_W + 1;

    localparam logic [DSM_DATA_W-1:0] DSM_MIDSCALE = 12'h800;

    // FIFO word as stored by the decimator and consumed by the framer
    typedef struct packed {
        logic                 clip;
        logic [DSM_OUT_W-1:0] data;
    } dsm_word_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } dsm_state_t;

endpackage

// File: rtl/dsm_sync_fifo.sv
// First-word-fall-through synchronous FIFO with register-array storage.
module dsm_sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a full FIFO still takes a push when the head leaves on the same edge
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsm_decimator.sv
// Boxcar decimator: sums 2^LOG2_DEC samples per word and queues words for the framer.
module dsm_decimator
    import dsm_pkg::*;
#(
    parameter int unsigned DATA_W   = DSM_DATA_W,
    parameter int unsigned SCALE_W  = DSM_SCALE_W,
    parameter int unsigned LOG2_DEC = DSM_LOG2_DEC,
    parameter int unsigned FIFO_AW  = DSM_FIFO_AW
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [SCALE_W-1:0]           in_scale,
    output logic [DATA_W+LOG2_DEC-1:0]   out_data,
    output logic                         out_clip,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FIFO_AW:0]             fifo_level,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int unsigned OUT_W = DATA_W + LOG2_DEC;

    dsm_state_t          state;
    dsm_state_t          state_nxt;
    logic [OUT_W-1:0]    acc;
    logic [OUT_W-1:0]    acc_nxt;
    logic [OUT_W-1:0]    acc_base;
    logic [OUT_W-1:0]    sum;
    logic [LOG2_DEC-1:0] cnt;
    logic [LOG2_DEC-1:0] cnt_nxt;
    logic                clip_acc;
    logic                clip_nxt;
    logic                clip_word;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OUT_W:0]      wr_word;
    logic [OUT_W:0]      rd_word;
    logic                unused_scale;

    // only the overload flag of the step scale matters here
    assign unused_scale = ^in_scale[SCALE_W-2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            acc      <= '0;
            cnt      <= '0;
            clip_acc <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            clip_acc <= clip_nxt;
        end
    end

    always_comb begin
        state_nxt = enable ? ST_ACCUM : ST_IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        clip_nxt  = 1'b0;
        push      = 1'b0;
        // the first sample is taken on the edge that leaves IDLE, so IDLE adds onto zero
        acc_base  = (state == ST_ACCUM) ? acc : '0;
        sum       = acc_base + OUT_W'(in_data);
        clip_word = ((state == ST_ACCUM) & clip_acc) | in_scale[SCALE_W-1];
        if (enable) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1) begin
                push = 1'b1;
            end else begin
                acc_nxt  = sum;
                clip_nxt = clip_word;
            end
        end
    end

    assign wr_word = {clip_word, sum};
    assign pop     = out_valid & out_ready;

    dsm_sync_fifo #(
        .WIDTH (OUT_W + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_word),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = rd_word[OUT_W-1:0];
    assign out_clip  = rd_word[OUT_W];

    // clear wins over a same-cycle drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end else if (push & fifo_full & ~pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// Scoreboarded bench for dsm_decimator: directed scenarios followed by randomized traffic.
module tb_dsm_decimator;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [11:0] in_data;
    logic [7:0]  in_scale;
    logic [15:0] out_data;
    logic        out_clip;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        clr_ovf;

    int errors = 0;
    int checks = 0;

    dsm_decimator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .in_data    (in_data),
        .in_scale   (in_scale),
        .out_data   (out_data),
        .out_clip   (out_clip),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window of raw samples, FIFO of expected words
    int          win_q[$];
    bit          win_clip;
    logic [16:0] exp_q[$];
    bit          m_ovf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q.delete();
            win_clip = 0;
            exp_q.delete();
            m_ovf = 0;
        end else begin
            bit   pop_now;
            bit   drop;
            int   s;
            pop_now = (exp_q.size() != 0) && out_ready;
            drop = 0;
            if (pop_now) void'(exp_q.pop_front());
            if (enable) begin
                win_q.push_back(int'(in_data));
                win_clip = win_clip | in_scale[7];
                if (win_q.size() == 16) begin
                    s = 0;
                    foreach (win_q[k]) s += win_q[k];
                    if (exp_q.size() < 8) exp_q.push_back({win_clip, 16'(s)});
                    else drop = 1;
                    win_q.delete();
                    win_clip = 0;
                end
            end else begin
                win_q.delete();
                win_clip = 0;
            end
            if (clr_ovf) m_ovf = 0;
            else if (drop) m_ovf = 1;
        end
    end

    // Monitor compares DUT outputs against the model every negedge
    always @(negedge clk) begin
        if (reset_n) begin
            chk("mon_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("mon_level", int'(fifo_level), exp_q.size());
            chk("mon_ovf", int'(overflow), int'(m_ovf));
            if (out_valid && exp_q.size() != 0) begin
                chk("mon_data", int'(out_data), int'(exp_q[0][15:0]));
                chk("mon_clip", int'(out_clip), int'(exp_q[0][16]));
            end
        end
    end

    task automatic drive(input logic en, input logic [11:0] d, input logic [7:0] s,
                         input logic r, input logic c);
        enable = en; in_data = d; in_scale = s; out_ready = r; clr_ovf = c;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_data"}, int'(out_data), 0);
        chk({name, "_clip"}, int'(out_clip), 0);
        chk({name, "_valid"}, int'(out_valid), 0);
        chk({name, "_level"}, int'(fifo_level), 0);
        chk({name, "_ovf"}, int'(overflow), 0);
    endtask

    initial begin
        int rdy_pct;
        reset_n = 1'b0;
        enable = 0; in_data = '0; in_scale = '0; out_ready = 0; clr_ovf = 0;

        // 1: reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            enable = 1'($urandom); in_data = 12'($urandom); in_scale = 8'($urandom);
            out_ready = 1'($urandom); clr_ovf = 1'($urandom);
            @(negedge clk);
            chk_zero("reset");
        end
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // 2: midscale constant, one word of 32768 valid for one cycle
        for (int i = 0; i < 16; i++) begin
            drive(1, 12'h800, 8'h01, 1, 0);
            if (i == 14) chk("mid_valid_early", int'(out_valid), 0);
        end
        chk("mid_valid", int'(out_valid), 1);
        chk("mid_data", int'(out_data), 32768);
        chk("mid_clip", int'(out_clip), 0);
        drive(0, 0, 0, 1, 0);
        chk("mid_valid_after", int'(out_valid), 0);

        // 3: ramp with overload flag on the 7th sample, then without
        for (int i = 0; i < 16; i++) drive(1, 12'(i), (i == 6) ? 8'h80 : 8'h01, 1, 0);
        chk("ramp_data", int'(out_data), 120);
        chk("ramp_clip", int'(out_clip), 1);
        for (int i = 0; i < 16; i++) drive(1, 12'(i), 8'h01, 1, 0);
        chk("ramp2_data", int'(out_data), 120);
        chk("ramp2_clip", int'(out_clip), 0);
        drive(0, 0, 0, 1, 0);

        // 4: full-scale windows with no consumer, ninth word dropped
        for (int i = 0; i < 9 * 16; i++) drive(1, 12'hfff, 8'h02, 0, 0);
        chk("full_level", int'(fifo_level), 8);
        chk("full_ovf", int'(overflow), 1);
        chk("full_data", int'(out_data), 65520);
        drive(0, 0, 0, 0, 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_level", int'(fifo_level), 8);

        // 5: full FIFO, pop on the window-end edge admits the new word
        for (int i = 0; i < 16; i++) drive(1, 12'hfff, 8'h02, (i == 15), 0);
        chk("fullpop_level", int'(fifo_level), 8);
        chk("fullpop_ovf", int'(overflow), 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0);
        chk("drain_level", int'(fifo_level), 0);

        // 6: partial window discarded on enable drop
        for (int i = 0; i < 10; i++) drive(1, 12'($urandom), 8'h04, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
        chk("partial_valid", int'(out_valid), 0);
        for (int i = 0; i < 16; i++) drive(1, 12'd100, 8'h04, 1, 0);
        chk("fresh_valid", int'(out_valid), 1);
        chk("fresh_data", int'(out_data), 1600);
        chk("fresh_level", int'(fifo_level), 1);
        drive(0, 0, 0, 1, 0);

        // Randomized traffic with alternating consumer pressure and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            rdy_pct = ((i / 200) % 2 != 0) ? 15 : 85;
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                chk_zero("midreset");
                reset_n = 1'b1;
            end
            drive($urandom_range(0, 19) != 0, 12'($urandom),
                  ($urandom_range(0, 15) == 0) ? 8'h80 : 8'(8'h01 << $urandom_range(0, 6)),
                  $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 0);
        chk("end_level", int'(fifo_level), 0);
        chk("end_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
